// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/grant/response channel
// plus the decode-side handoff (ValidD/InstrD/PCD, stall and redirect).
interface fetch_unit_if;
  // Instruction memory channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Decode handoff and Execute redirect
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        StallD;
  logic        PCsrcE;
  logic [31:0] PCTargetE;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, ValidD, InstrD, PCD, PCPlus4D,
    input  imem_gnt, imem_rvalid, imem_rdata, StallD, PCsrcE, PCTargetE
  );

  // Memory / pipeline environment side
  modport slave (
    input  imem_req, imem_addr, ValidD, InstrD, PCD, PCPlus4D,
    output imem_gnt, imem_rvalid, imem_rdata, StallD, PCsrcE, PCTargetE
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Generates the PC, issues fetches to instruction
// memory, buffers up to DEPTH instructions in a circular buffer and hands
// them to decode in program order. A redirect from Execute flushes the
// buffer and arranges for responses still in flight to be thrown away.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Fetch PC and buffer storage
  logic [31:0]      pc_q;
  logic [31:0]      entry_pc   [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_filled;

  // head = oldest entry, tail = next slot to allocate,
  // fill = oldest allocated slot still waiting for its response
  ptr_t head_q;
  ptr_t tail_q;
  ptr_t fill_q;

  // count = allocated slots, outstanding = allocated but unfilled,
  // discard = stale responses still to be dropped after a redirect
  cnt_t count_q;
  cnt_t outstanding_q;
  cnt_t discard_q;

  logic        redirect;
  logic        issue;
  logic        consume;
  logic        accept_rsp;
  logic        drop_rsp;
  logic        rsp_now;
  logic        valid_d;
  logic [31:0] pcd;
  logic [CW:0] occ_sum;
  cnt_t        in_flight;
  cnt_t        discard_next;

  // Request, response and consume decisions for the current cycle
  always_comb begin
    redirect     = bus.PCsrcE;
    occ_sum      = {1'b0, count_q} + {1'b0, discard_q};
    bus.imem_req = ~rst & ~redirect & (occ_sum < DEPTH_W);
    bus.imem_addr = pc_q;
    issue        = bus.imem_req & bus.imem_gnt;

    valid_d      = (count_q != '0) & entry_filled[head_q];
    consume      = valid_d & ~bus.StallD & ~redirect;

    drop_rsp     = bus.imem_rvalid & (discard_q != '0);
    accept_rsp   = bus.imem_rvalid & (discard_q == '0) & (outstanding_q != '0);

    in_flight    = outstanding_q + discard_q;
    rsp_now      = bus.imem_rvalid & (in_flight != '0);
    discard_next = in_flight - cnt_t'(rsp_now);
  end

  // Decode-facing outputs come straight from the head entry
  always_comb begin
    pcd          = entry_pc[head_q];
    bus.ValidD   = valid_d;
    bus.InstrD   = valid_d ? entry_data[head_q] : NOP;
    bus.PCD      = pcd;
    bus.PCPlus4D = pcd + 32'd4;
  end

  // PC, pointers and counters; a redirect wins over every other event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else if (redirect) begin
      pc_q          <= {bus.PCTargetE[31:2], 2'b00};
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= discard_next;
    end else begin
      if (issue) begin
        pc_q   <= pc_q + 32'd4;
        tail_q <= tail_q + ptr_t'(1);
      end
      if (accept_rsp) begin
        fill_q <= fill_q + ptr_t'(1);
      end
      if (consume) begin
        head_q <= head_q + ptr_t'(1);
      end
      if (drop_rsp) begin
        discard_q <= discard_q - cnt_t'(1);
      end
      count_q       <= count_q + cnt_t'(issue) - cnt_t'(consume);
      outstanding_q <= outstanding_q + cnt_t'(issue) - cnt_t'(accept_rsp);
    end
  end

  // Buffer entries: allocate on issue, fill on an accepted response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc[i]   <= '0;
        entry_data[i] <= NOP;
      end
      entry_filled <= '0;
    end else if (redirect) begin
      entry_filled <= '0;
    end else begin
      if (issue) begin
        entry_pc[tail_q]     <= pc_q;
        entry_filled[tail_q] <= 1'b0;
      end
      if (accept_rsp) begin
        entry_data[fill_q]   <= bus.imem_rdata;
        entry_filled[fill_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: an in-order memory model with configurable
// grant pattern and latency, a table of redirect/stream vectors, and
// hand-written sequences for stall, redirect and reset corner cases.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h00000000), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Memory model state
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    cyc          = 0;
  int    last_due     = 0;
  int    max_inflight = 0;
  int    gnt_mode     = 0;
  int    max_lat      = 1;
  logic  gnt_en       = 1'b1;
  logic  resp_hold    = 1'b0;

  typedef struct {
    logic [31:0] target;
    int          gnt_mode;
    int          max_lat;
    int          stall_mode;
    int          count;
    logic [31:0] first_pc;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // In-order memory: grants per gnt_mode, answers after 1..max_lat cycles
  initial begin
    int    lat;
    int    due;
    pend_t item;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (!resp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend[0].addr ^ KEY;
        void'(pend.pop_front());
      end
      bus.imem_gnt = gnt_en && (gnt_mode == 0 || cyc[0]);
      #3;
      if (bus.imem_req && bus.imem_gnt) begin
        lat = $urandom_range(max_lat, 1);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due  = due;
        item.addr = bus.imem_addr;
        item.due  = due;
        pend.push_back(item);
      end
      if (pend.size() > max_inflight) max_inflight = pend.size();
    end
  end

  task automatic doReset(input logic stall);
    @(negedge clk);
    rst = 1'b1;
    bus.PCsrcE = 1'b0;
    pend.delete();
    last_due = 0;
    repeat (2) @(negedge clk);
    bus.StallD = stall;
    rst = 1'b0;
  endtask

  // One-cycle redirect pulse; fetch must not request in that cycle
  task automatic applyStimulus(input logic [31:0] target);
    @(negedge clk);
    bus.StallD    = 1'b0;
    bus.PCsrcE    = 1'b1;
    bus.PCTargetE = target;
    #4;
    checkOutput("redirect.req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    bus.PCsrcE = 1'b0;
  endtask

  // Collect n consumed instructions and compare against a sequential PC model
  task automatic runStream(input string tag, input int n,
                           input logic [31:0] first_pc, input int stall_mode);
    logic [31:0] exp_pc;
    int got;
    int cycles;
    exp_pc = first_pc;
    got    = 0;
    cycles = 0;
    max_inflight = 0;
    while (got < n && cycles < 300) begin
      @(negedge clk);
      bus.StallD = (stall_mode == 1) && (cycles % 3 == 1);
      cycles++;
      #4;
      if (bus.ValidD && !bus.StallD) begin
        checkOutput({tag, ".pcd"}, bus.PCD, exp_pc);
        checkOutput({tag, ".instr"}, bus.InstrD, exp_pc ^ KEY);
        checkOutput({tag, ".pcplus4"}, bus.PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    checkOutput({tag, ".count"}, 32'(got), 32'(n));
    checkOutput({tag, ".inflight_le2"}, 32'(max_inflight <= 2), 32'd1);
  endtask

  task automatic waitPending(input string tag, input int n);
    int cycles;
    cycles = 0;
    while (pend.size() < n && cycles < 50) begin
      @(negedge clk);
      #4;
      cycles++;
    end
    checkOutput({tag, ".pending"}, 32'(pend.size()), 32'(n));
  endtask

  initial begin
    bus.StallD    = 1'b0;
    bus.PCsrcE    = 1'b0;
    bus.PCTargetE = '0;

    vecs[0] = '{32'h00000400, 0, 1, 0, 6, 32'h00000400};
    vecs[1] = '{32'h00000802, 1, 3, 0, 6, 32'h00000800};
    vecs[2] = '{32'hFFFFFFF5, 1, 3, 0, 5, 32'hFFFFFFF4};
    vecs[3] = '{32'h00001000, 0, 1, 1, 6, 32'h00001000};
    vecs[4] = '{32'hFFFFFFFB, 1, 2, 1, 4, 32'hFFFFFFF8};

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    checkOutput("reset.req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset.valid", 32'(bus.ValidD), 32'd0);
    checkOutput("reset.instr", bus.InstrD, NOP);
    checkOutput("reset.pcd", bus.PCD, 32'd0);
    checkOutput("reset.pcplus4", bus.PCPlus4D, 32'd4);

    // Straight-line fetch from RESET_PC
    @(negedge clk);
    rst = 1'b0;
    #4;
    checkOutput("start.req", 32'(bus.imem_req), 32'd1);
    checkOutput("start.addr", bus.imem_addr, 32'd0);
    runStream("seq", 4, 32'h0, 0);

    // Decode stall: buffer fills to 2, requests stop, head held
    doReset(1'b1);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      checkOutput("stall.req", 32'(bus.imem_req), 32'd0);
      checkOutput("stall.valid", 32'(bus.ValidD), 32'd1);
      checkOutput("stall.pcd", bus.PCD, 32'h0);
      checkOutput("stall.instr", bus.InstrD, KEY);
    end
    runStream("stall_release", 3, 32'h0, 0);

    // Redirect with two requests outstanding
    doReset(1'b0);
    resp_hold = 1'b1;
    waitPending("redir2", 2);
    @(negedge clk);
    bus.PCsrcE    = 1'b1;
    bus.PCTargetE = 32'h00000103;
    #4;
    checkOutput("redir2.req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    bus.PCsrcE = 1'b0;
    resp_hold  = 1'b0;
    #4;
    checkOutput("redir2.addr", bus.imem_addr, 32'h00000100);
    runStream("redir2", 3, 32'h00000100, 0);

    // Redirect coinciding with a response and a consume (nothing left to discard)
    doReset(1'b0);
    resp_hold = 1'b1;
    waitPending("redir_cons", 2);
    @(negedge clk);
    resp_hold = 1'b0;
    @(negedge clk);
    bus.PCsrcE    = 1'b1;
    bus.PCTargetE = 32'h00000200;
    #4;
    checkOutput("redir_cons.valid", 32'(bus.ValidD), 32'd1);
    checkOutput("redir_cons.pcd", bus.PCD, 32'h0);
    checkOutput("redir_cons.rvalid", 32'(bus.imem_rvalid), 32'd1);
    @(negedge clk);
    bus.PCsrcE = 1'b0;
    runStream("redir_cons", 2, 32'h00000200, 0);

    // Redirect coinciding with a response while one more is still in flight
    doReset(1'b0);
    resp_hold = 1'b1;
    waitPending("redir_rsp", 2);
    @(negedge clk);
    resp_hold     = 1'b0;
    bus.PCsrcE    = 1'b1;
    bus.PCTargetE = 32'h00000300;
    #4;
    checkOutput("redir_rsp.rvalid", 32'(bus.imem_rvalid), 32'd1);
    @(negedge clk);
    bus.PCsrcE = 1'b0;
    runStream("redir_rsp", 2, 32'h00000300, 0);

    // Table-driven redirect/stream vectors
    for (int v = 0; v < 5; v++) begin
      gnt_mode = vecs[v].gnt_mode;
      max_lat  = vecs[v].max_lat;
      applyStimulus(vecs[v].target);
      runStream($sformatf("vec%0d", v), vecs[v].count, vecs[v].first_pc,
                vecs[v].stall_mode);
    end
    gnt_mode = 0;
    max_lat  = 1;

    // Reset with two requests outstanding; late responses must be ignored
    doReset(1'b0);
    resp_hold = 1'b1;
    waitPending("late", 2);
    @(negedge clk);
    gnt_en = 1'b0;
    rst    = 1'b1;
    #4;
    checkOutput("late.rst_valid", 32'(bus.ValidD), 32'd0);
    checkOutput("late.rst_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    resp_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      checkOutput("late.valid", 32'(bus.ValidD), 32'd0);
      checkOutput("late.instr", bus.InstrD, NOP);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    runStream("late", 2, 32'h0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the pipelined core: the producer side of the decode interface. It generates the PC, fetches from instruction memory over a request/grant/response interface, and buffers up to DEPTH instructions.
- It presents InstrD/PCD with a valid flag to the control unit and decode stage.
- It honours decode stalls and redirects from branch/jump resolution in Execute.

Parameters:
RESET_PC, 32'h00000000, PC fetched first after reset
DEPTH, 2, instruction buffer entries; also the maximum number of outstanding memory requests (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (word aligned)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after grant
imem_rdata  in  32  instruction word
ValidD  out  1  InstrD/PCD hold a valid instruction
InstrD  out  32  instruction to decode
PCD  out  32  PC of InstrD
PCPlus4D  out  32  PCD + 4
StallD  in  1  decode cannot accept; hold outputs
PCsrcE  in  1  redirect request (taken branch/jump)
PCTargetE  in  32  redirect target

Behaviour:
Reset values:
- pc_q = RESET_PC.
- All buffer entries invalid; outstanding = 0; discard_cnt = 0.
- imem_req = 0; ValidD = 0; InstrD = 32'h00000013 (NOP); PCD = 0; PCPlus4D = 4.

Buffer:
- Circular buffer of DEPTH entries, each holding {pc, data, filled}, with head/tail pointers and an occupancy count.
- A slot is allocated (tail++, pc recorded, filled = 0) when a request is granted.
- The oldest unfilled slot is filled when a non-discarded response arrives.

Request rule:
- imem_req = ~rst & ~PCsrcE & (occupancy < DEPTH).
- imem_addr = pc_q.
- Issue = imem_req & imem_gnt; on issue, pc_q <= pc_q + 4 (wraps at 2^32).

Output:
- ValidD = head entry allocated & filled.
- InstrD/PCD come from the head entry; InstrD = NOP when ValidD = 0.
- PCPlus4D = PCD + 4, combinational.

Consume:
- ValidD & ~StallD frees the head (head++, occupancy--).
- While StallD = 1, outputs remain stable.

Simultaneous events:
- Issue, response fill and consume may all occur in one cycle.
- Occupancy updates by +issue -consume.
- A slot freed in a cycle is not reusable until the next cycle; the req decision uses the registered occupancy.

Redirect (PCsrcE = 1, any cycle, overrides everything):
- All buffer entries are invalidated; occupancy = 0.
- pc_q <= {PCTargetE[31:2], 2'b00}.
- imem_req = 0 in this cycle.
- discard_cnt <= number of requests granted but not yet responded (excluding any response arriving this same cycle, which is also dropped).
- The consume in the redirect cycle is ignored; decode flushes itself.

Discard:
- While discard_cnt > 0, each imem_rvalid is dropped and discard_cnt decrements.
- New requests may issue during discard; their responses follow the dropped ones in order.
- Buffer allocation plus discard_cnt must never exceed DEPTH in flight; req also requires occupancy + discard_cnt < DEPTH.

Errors and reset:
- imem_rvalid with nothing outstanding and discard_cnt = 0 is ignored.
- Asserting rst mid-operation returns every register to its reset value immediately; responses to pre-reset requests arriving after reset are ignored.

Throughput: one instruction per cycle sustained when the memory grants every cycle with fixed latency <= DEPTH-1.

Test Plan:
1. Reset, then imem_gnt = 1, 1-cycle latency, rdata = addr ^ 32'hA5A5A5A5, StallD = 0 -> PCD sequence 0, 4, 8, 12 on consecutive cycles after a 2-cycle fill; InstrD matches; PCPlus4D = PCD + 4.
2. StallD = 1 for 5 cycles with DEPTH = 2 -> imem_req drops after 2 allocations; ValidD = 1 with PCD held at 0x0; release -> 0x4, 0x8 follow with no gaps or duplicates.
3. PCsrcE pulse with PCTargetE = 32'h00000103 while 2 requests are outstanding -> next imem_addr = 0x100; the 2 stale responses are dropped; first ValidD shows PCD = 0x100.
4. Redirect in the same cycle as imem_rvalid and consume -> response dropped, no consume effect, discard_cnt equals remaining outstanding (0 or 1), then fetch resumes at target.
5. imem_gnt toggling 1/0 with random 1–3 cycle latency -> in-order, gap-free PCD stream; occupancy never exceeds 2; pc_q wraps from 0xFFFFFFFC to 0x0.
6. Assert rst with 2 outstanding requests, deassert, then deliver 2 late responses -> both ignored; ValidD = 0 and InstrD = 0x00000013 until the first new fetch at RESET_PC.
